// File: rtl/apb_to_obi_bridge_if.sv
// Purpose: APB4 completer + OBI manager signal bundle for apb_to_obi_bridge.
// Latency: n/a (wires only).
// Backpressure: APB is stretched via pready_o; OBI request held until obi_gnt_i.
// Ports: 'slave' modport is the bridge view (APB in, OBI request out);
//        'master' modport is the environment view (drives APB, answers OBI).
interface apb_to_obi_bridge_if #(
   parameter int AddrWidth = 32,
   parameter int DataWidth = 32
);
   localparam int BeWidth = DataWidth / 8;

   // APB side
   logic [AddrWidth-1:0] paddr_i;
   logic                 psel_i;
   logic                 penable_i;
   logic                 pwrite_i;
   logic [DataWidth-1:0] pwdata_i;
   logic [BeWidth-1:0]   pstrb_i;
   logic [2:0]           pprot_i;
   logic                 pready_o;
   logic [DataWidth-1:0] prdata_o;
   logic                 pslverr_o;

   // OBI side
   logic                 obi_req_o;
   logic                 obi_gnt_i;
   logic [AddrWidth-1:0] obi_addr_o;
   logic                 obi_we_o;
   logic [BeWidth-1:0]   obi_be_o;
   logic [DataWidth-1:0] obi_wdata_o;
   logic                 obi_rvalid_i;
   logic [DataWidth-1:0] obi_rdata_i;
   logic                 obi_err_i;

   modport slave (
      input  paddr_i, psel_i, penable_i, pwrite_i, pwdata_i, pstrb_i, pprot_i,
      output pready_o, prdata_o, pslverr_o,
      output obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o,
      input  obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i
   );

   modport master (
      output paddr_i, psel_i, penable_i, pwrite_i, pwdata_i, pstrb_i, pprot_i,
      input  pready_o, prdata_o, pslverr_o,
      input  obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o,
      output obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i
   );
endinterface

// File: rtl/apb_to_obi_bridge.sv
// Purpose: APB4 completer turning each APB transfer into exactly one OBI manager transaction.
// Latency: setup T0 -> OBI req T1 -> response T2 at best -> pready_o T3 (two APB wait states).
// Backpressure: one transfer in flight; APB access stretched (pready_o=0) until OBI response returns.
// Ports: clk_i, rst_ni (async active-low), bus (apb_to_obi_bridge_if.slave: APB + OBI signals).
module apb_to_obi_bridge #(
   parameter int                   AddrWidth  = 32,
   parameter int                   DataWidth  = 32,
   parameter logic [AddrWidth-1:0] AddrOffset = '0
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   apb_to_obi_bridge_if.slave      bus
);
   localparam int BeWidth = DataWidth / 8;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

   state_e               state_q, state_d;
   logic [AddrWidth-1:0] addr_q, addr_d;
   logic                 we_q, we_d;
   logic [BeWidth-1:0]   be_q, be_d;
   logic [DataWidth-1:0] wdata_q, wdata_d;
   logic [DataWidth-1:0] prdata_q, prdata_d;
   logic                 pslverr_q, pslverr_d;

   // Protection attributes have no OBI counterpart here.
   logic unused_pprot;
   assign unused_pprot = ^bus.pprot_i;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      we_d      = we_q;
      be_d      = be_q;
      wdata_d   = wdata_q;
      prdata_d  = prdata_q;
      pslverr_d = pslverr_q;
      case (state_q)
         IDLE: begin
            // Capture on the setup phase so the OBI request goes out in the
            // first access cycle. Address add wraps naturally at AddrWidth.
            if (bus.psel_i && !bus.penable_i) begin
               addr_d  = bus.paddr_i + AddrOffset;
               we_d    = bus.pwrite_i;
               wdata_d = bus.pwdata_i;
               be_d    = bus.pwrite_i ? bus.pstrb_i : '1;
               state_d = REQ;
            end
         end
         REQ: begin
            if (bus.obi_gnt_i) state_d = WAIT;
         end
         WAIT: begin
            if (bus.obi_rvalid_i) begin
               prdata_d  = we_q ? '0 : bus.obi_rdata_i;
               pslverr_d = bus.obi_err_i;
               state_d   = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         we_q      <= 1'b0;
         be_q      <= '0;
         wdata_q   <= '0;
         prdata_q  <= '0;
         pslverr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         be_q      <= be_d;
         wdata_q   <= wdata_d;
         prdata_q  <= prdata_d;
         pslverr_q <= pslverr_d;
      end
   end

   // Request fields come straight from registers, so they are stable while
   // obi_req_o waits for grant.
   assign bus.obi_req_o   = (state_q == REQ);
   assign bus.obi_addr_o  = addr_q;
   assign bus.obi_we_o    = we_q;
   assign bus.obi_be_o    = be_q;
   assign bus.obi_wdata_o = wdata_q;
   assign bus.pready_o    = (state_q == RESP);
   assign bus.prdata_o    = prdata_q;
   assign bus.pslverr_o   = pslverr_q;
endmodule

// File: tb/tb_apb_to_obi_bridge.sv
// Purpose: self-checking bench for apb_to_obi_bridge (scoreboard of OBI requests and APB responses).
// Latency: n/a.
// Backpressure: bench-driven OBI grant/rvalid delays.
module tb_apb_to_obi_bridge;
   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk_i = ~clk_i;

   apb_to_obi_bridge_if #(.AddrWidth(32), .DataWidth(32)) bus ();
   apb_to_obi_bridge_if #(.AddrWidth(32), .DataWidth(32)) bus_off ();

   apb_to_obi_bridge #(.AddrWidth(32), .DataWidth(32), .AddrOffset(32'h0)) u_dut (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .bus   (bus)
   );

   // Second instance with a wrapping offset, fed the same stimulus.
   apb_to_obi_bridge #(.AddrWidth(32), .DataWidth(32), .AddrOffset(32'h8000_0000)) u_dut_off (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .bus   (bus_off)
   );

   assign bus_off.paddr_i      = bus.paddr_i;
   assign bus_off.psel_i       = bus.psel_i;
   assign bus_off.penable_i    = bus.penable_i;
   assign bus_off.pwrite_i     = bus.pwrite_i;
   assign bus_off.pwdata_i     = bus.pwdata_i;
   assign bus_off.pstrb_i      = bus.pstrb_i;
   assign bus_off.pprot_i      = bus.pprot_i;
   assign bus_off.obi_gnt_i    = bus.obi_gnt_i;
   assign bus_off.obi_rvalid_i = bus.obi_rvalid_i;
   assign bus_off.obi_rdata_i  = bus.obi_rdata_i;
   assign bus_off.obi_err_i    = bus.obi_err_i;

   typedef struct {
      logic [31:0] addr0;
      logic [31:0] addr1;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } req_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } resp_t;

   req_t  req_q[$];
   resp_t resp_q[$];

   int n_tests    = 0;
   int n_fail     = 0;
   int n_grants   = 0;
   int n_xfers    = 0;
   int req_cycles = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Monitor: compare request fields every REQ cycle, pop on grant; pop
   // response expectations when pready_o pulses.
   always @(negedge clk_i) begin
      if (rst_ni) begin
         if (bus.obi_req_o) begin
            req_cycles++;
            if (req_q.size() == 0) begin
               chk("req_unexpected", 32'd1, 32'd0);
            end else begin
               chk("obi_addr",  bus.obi_addr_o, req_q[0].addr0);
               chk("obi_we",    {31'd0, bus.obi_we_o}, {31'd0, req_q[0].we});
               chk("obi_be",    {28'd0, bus.obi_be_o}, {28'd0, req_q[0].be});
               chk("obi_wdata", bus.obi_wdata_o, req_q[0].wdata);
               chk("off_req",   {31'd0, bus_off.obi_req_o}, 32'd1);
               chk("off_addr",  bus_off.obi_addr_o, req_q[0].addr1);
               if (bus.obi_gnt_i) begin
                  n_grants++;
                  void'(req_q.pop_front());
               end
            end
         end
         if (bus.pready_o) begin
            if (resp_q.size() == 0) begin
               chk("pready_unexpected", 32'd1, 32'd0);
            end else begin
               chk("prdata",  bus.prdata_o, resp_q[0].rdata);
               chk("pslverr", {31'd0, bus.pslverr_o}, {31'd0, resp_q[0].err});
               void'(resp_q.pop_front());
            end
         end
      end
   end

   // Called at posedge+1 of the cycle that should carry the setup phase;
   // returns at posedge+1 of the cycle after RESP with APB idle.
   task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                       input logic [3:0] strb, input int gdly, input int rdly,
                       input logic [31:0] rd, input logic er);
      req_t  r;
      resp_t s;
      r.addr0 = addr;
      r.addr1 = addr + 32'h8000_0000;
      r.we    = wr;
      r.be    = wr ? strb : 4'hF;
      r.wdata = wd;
      req_q.push_back(r);
      n_xfers++;
      bus.psel_i    = 1'b1;
      bus.penable_i = 1'b0;
      bus.paddr_i   = addr;
      bus.pwrite_i  = wr;
      bus.pwdata_i  = wd;
      bus.pstrb_i   = strb;
      @(posedge clk_i); #1;
      bus.penable_i = 1'b1;
      repeat (gdly) begin @(posedge clk_i); #1; end
      bus.obi_gnt_i = 1'b1;
      @(posedge clk_i); #1;
      bus.obi_gnt_i = 1'b0;
      repeat (rdly) begin @(posedge clk_i); #1; end
      bus.obi_rvalid_i = 1'b1;
      bus.obi_rdata_i  = rd;
      bus.obi_err_i    = er;
      s.rdata = wr ? 32'd0 : rd;
      s.err   = er;
      resp_q.push_back(s);
      @(posedge clk_i); #1;
      bus.obi_rvalid_i = 1'b0;
      bus.obi_rdata_i  = 32'h0;
      bus.obi_err_i    = 1'b0;
      @(negedge clk_i);
      chk("pready_pulse", {31'd0, bus.pready_o}, 32'd1);
      @(posedge clk_i); #1;
      bus.psel_i    = 1'b0;
      bus.penable_i = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req"},     {31'd0, bus.obi_req_o}, 32'd0);
      chk({tag, "_addr"},    bus.obi_addr_o, 32'd0);
      chk({tag, "_we"},      {31'd0, bus.obi_we_o}, 32'd0);
      chk({tag, "_be"},      {28'd0, bus.obi_be_o}, 32'd0);
      chk({tag, "_wdata"},   bus.obi_wdata_o, 32'd0);
      chk({tag, "_pready"},  {31'd0, bus.pready_o}, 32'd0);
      chk({tag, "_prdata"},  bus.prdata_o, 32'd0);
      chk({tag, "_pslverr"}, {31'd0, bus.pslverr_o}, 32'd0);
   endtask

   int rc0;

   initial begin
      bus.paddr_i      = '0;
      bus.psel_i       = 1'b0;
      bus.penable_i    = 1'b0;
      bus.pwrite_i     = 1'b0;
      bus.pwdata_i     = '0;
      bus.pstrb_i      = '0;
      bus.pprot_i      = 3'b010;
      bus.obi_gnt_i    = 1'b0;
      bus.obi_rvalid_i = 1'b0;
      bus.obi_rdata_i  = '0;
      bus.obi_err_i    = 1'b0;

      repeat (3) @(posedge clk_i);
      #1;
      chk_reset_outputs("rst");
      rst_ni = 1'b1;
      @(posedge clk_i); #1;

      // Single read, fastest OBI response.
      xfer(32'h0000_1004, 1'b0, 32'h0, 4'h0, 0, 0, 32'hDEAD_BEEF, 1'b0);
      // Write with partial strobes, back-to-back after the read.
      xfer(32'h0000_0020, 1'b1, 32'h1234_5678, 4'b0011, 0, 0, 32'hFFFF_FFFF, 1'b0);
      @(posedge clk_i); #1;

      // Stalled grant and response: six REQ cycles, one grant.
      rc0 = req_cycles;
      xfer(32'h0000_0108, 1'b0, 32'hA5A5_5A5A, 4'hC, 5, 3, 32'h0BAD_F00D, 1'b0);
      chk("stall_req_cycles", rc0 + 6 > req_cycles ? 32'(req_cycles - rc0) : 32'(req_cycles - rc0), 32'd6);

      // Error response, followed by a good transfer clearing pslverr.
      xfer(32'h0000_2000, 1'b0, 32'h0, 4'h0, 1, 0, 32'h5555_AAAA, 1'b1);
      xfer(32'h0000_2004, 1'b0, 32'h0, 4'h0, 0, 1, 32'h1111_2222, 1'b0);

      // Offset wrap on the second instance: 0x8000_0010 + 0x8000_0000 = 0x10.
      xfer(32'h8000_0010, 1'b1, 32'hCAFE_0001, 4'b1000, 2, 0, 32'h0, 1'b0);
      chk("wrap_addr", bus_off.obi_addr_o, 32'h0000_0010);

      // A few randomized transfers for variety.
      for (int i = 0; i < 6; i++) begin
         xfer({$urandom_range(0, 32'hFFFF), 2'b00} + 32'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)));
         if (i % 2 == 1) begin @(posedge clk_i); #1; end
      end

      // Reset while waiting for the OBI response, then a stray rvalid.
      req_q.push_back('{addr0: 32'h0000_0300, addr1: 32'h8000_0300, we: 1'b0, be: 4'hF, wdata: 32'h0});
      n_xfers++;
      bus.psel_i    = 1'b1;
      bus.penable_i = 1'b0;
      bus.paddr_i   = 32'h0000_0300;
      bus.pwrite_i  = 1'b0;
      bus.pwdata_i  = 32'h0;
      @(posedge clk_i); #1;
      bus.penable_i = 1'b1;
      bus.obi_gnt_i = 1'b1;
      @(posedge clk_i); #1;
      bus.obi_gnt_i = 1'b0;
      @(posedge clk_i); #1;
      rst_ni = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      bus.psel_i    = 1'b0;
      bus.penable_i = 1'b0;
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
      bus.obi_rvalid_i = 1'b1;
      bus.obi_rdata_i  = 32'hBAD0_BAD0;
      bus.obi_err_i    = 1'b1;
      @(posedge clk_i); #1;
      bus.obi_rvalid_i = 1'b0;
      bus.obi_rdata_i  = 32'h0;
      bus.obi_err_i    = 1'b0;
      @(negedge clk_i);
      chk("stray_pready",  {31'd0, bus.pready_o}, 32'd0);
      chk("stray_prdata",  bus.prdata_o, 32'd0);
      chk("stray_pslverr", {31'd0, bus.pslverr_o}, 32'd0);
      @(posedge clk_i); #1;

      xfer(32'h0000_0404, 1'b0, 32'h0, 4'h0, 1, 1, 32'h7777_8888, 1'b0);
      repeat (3) @(posedge clk_i);
      #1;

      chk("req_q_empty",  32'(req_q.size()), 32'd0);
      chk("resp_q_empty", 32'(resp_q.size()), 32'd0);
      chk("grant_count",  32'(n_grants), 32'(n_xfers));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
